// File: rtl/tohost_ctrl_if.sv
// Core-side tohost port and console character stream of the run controller.
// The master side is the core/harness; the slave side is tohost_ctrl.
interface tohost_ctrl_if;
  logic        core_rstn;
  logic        tohost_we;
  logic [31:0] tohost;
  logic        putc_valid;
  logic [7:0]  putc_data;
  logic        putc_ready;

  modport master (
    input  core_rstn,
    input  putc_valid,
    input  putc_data,
    output tohost_we,
    output tohost,
    output putc_ready
  );

  modport slave (
    output core_rstn,
    output putc_valid,
    output putc_data,
    input  tohost_we,
    input  tohost,
    input  putc_ready
  );
endinterface

// File: rtl/tohost_ctrl.sv
// Test-run sequencer: holds the core in reset, runs it, decodes tohost writes
// into console characters or an exit code, and stops the run on a watchdog.
//
//   state  | meaning
//   S_IDLE | core held in reset, waiting for start
//   S_RUN  | core running, tohost writes decoded, cycles counting
//   S_DONE | core held in reset, results frozen until the next start
module tohost_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  tohost_ctrl_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [30:0]       exit_code,
  output logic [CNT_W-1:0]  cycles,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_W-1:0] WD_LOAD =
    (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              core_rstn_q, core_rstn_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [30:0]       exit_code_q, exit_code_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic              overflow_q, overflow_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0] cnt_q;

  logic is_console, wr_run, con_wr, exit_wr, wd_hit;
  logic fifo_full, fifo_nempty, push, pop, drop;

  assign is_console  = (bus.tohost[31:16] == 16'h0101);
  assign wr_run      = (state_q == S_RUN) && bus.tohost_we;
  assign con_wr      = wr_run && is_console;
  assign exit_wr     = wr_run && !is_console && bus.tohost[0];
  // Watchdog is a down-counter loaded on RUN entry; terminal count is zero.
  assign wd_hit      = (MAX_CYCLES != 0) && (wd_q == '0);

  assign fifo_nempty = (cnt_q != '0);
  assign fifo_full   = (cnt_q == FIFO_FULL);
  assign pop         = fifo_nempty && bus.putc_ready;
  assign push        = con_wr && (!fifo_full || pop);
  assign drop        = con_wr && fifo_full && !pop;

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    cycles_d    = cycles_q;
    wd_d        = wd_q;
    overflow_d  = overflow_q | drop;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          exit_code_d = '0;
          cycles_d    = '0;
          wd_d        = WD_LOAD;
          overflow_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (exit_wr) begin
          state_d     = S_DONE;
          exit_code_d = bus.tohost[31:1];
          pass_d      = (bus.tohost[31:1] == 31'd0);
        end else if (wd_hit) begin
          state_d     = S_DONE;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          exit_code_d = '0;
        end else begin
          // cycles only advances while staying in RUN, so it freezes at the exit edge
          cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
          wd_d     = (wd_q == '0) ? wd_q : wd_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_rstn_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      core_rstn_q <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
      cycles_q    <= '0;
      wd_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rstn_q <= core_rstn_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      exit_code_q <= exit_code_d;
      cycles_q    <= cycles_d;
      wd_q        <= wd_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.tohost[7:0];
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_FW'(1);
        2'b01:   cnt_q <= cnt_q - CNT_FW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.core_rstn  = core_rstn_q;
  assign bus.putc_valid = fifo_nempty;
  assign bus.putc_data  = fifo_nempty ? mem_q[rd_ptr_q] : 8'h00;

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_code_q;
  assign cycles    = cycles_q;
  assign overflow  = overflow_q;

endmodule
